// File: rtl/spart_fifo.sv
// -----------------------------------------------------------------------------
// spart_fifo -- simple programmable asynchronous receiver/transmitter with
// RX and TX FIFOs behind a small 8-bit register bus.
//
// Register map (ioaddr):
//   00  data      read: pop RX FIFO head (8'h00 when empty); write: push TX FIFO
//   01  status    read: {3'b0, overrun, parity_err, frame_err, rda, tbr}
//                 write: each 1 in databus[4:2] clears the matching sticky bit
//   10  divisor low byte  (write only, resets the baud counter)
//   11  divisor high byte (write only, resets the baud counter)
//
// Ports:
//   clk      single clock, all logic on the rising edge
//   rst      synchronous, active-high reset
//   iocs     bus chip select
//   iorw     1 = read, 0 = write
//   ioaddr   register select (see map above)
//   databus  bidirectional bus; driven only for reads of 00/01
//   rda      RX FIFO not empty
//   tbr      TX FIFO not full
//   txd      serial transmit line (idle high)
//   rxd      serial receive line, asynchronous to clk
//
// Bus handshake: a register access is a single cycle qualified by iocs.
// Writes take effect at the rising edge while iocs=1/iorw=0; a data read
// shows the RX head combinationally and pops it at the same edge, so a
// read held for N edges pops N entries.
//
// Baud: a one-cycle tick fires every divisor+1 clocks; every serial bit
// lasts 16 ticks. The FSM state registers tx_state / rx_state are of type
// bit_state_t and can be probed hierarchically.
// -----------------------------------------------------------------------------
module spart_fifo #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PARITY_EN  = 0,
    parameter int          PARITY_ODD = 0,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] DIV_RST    = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int           AW         = $clog2(FIFO_DEPTH);
    localparam int           CW         = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam int           STOP_TICKS = STOP_BITS * 16;
    localparam logic         ODD        = (PARITY_ODD != 0);
    localparam logic         PAR_ON     = (PARITY_EN != 0);
    localparam logic [2:0]   LAST_BIT   = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } bit_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic data_rd, stat_rd, data_wr, stat_wr, divl_wr, divh_wr;

    assign data_rd = iocs &  iorw & (ioaddr == 2'b00);
    assign stat_rd = iocs &  iorw & (ioaddr == 2'b01);
    assign data_wr = iocs & ~iorw & (ioaddr == 2'b00);
    assign stat_wr = iocs & ~iorw & (ioaddr == 2'b01);
    assign divl_wr = iocs & ~iorw & (ioaddr == 2'b10);
    assign divh_wr = iocs & ~iorw & (ioaddr == 2'b11);

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [15:0] divisor;
    logic [15:0] baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == divisor);

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= DIV_RST;
            baud_cnt <= '0;
        end else begin
            if (divl_wr) divisor[7:0]  <= databus;
            if (divh_wr) divisor[15:8] <= databus;
            // Restarting the count keeps a new divisor from waiting out a
            // long wrap of the old one.
            if (divl_wr || divh_wr) baud_cnt <= '0;
            else if (tick)          baud_cnt <= '0;
            else                    baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp, tx_rp;
    logic [CW-1:0]     tx_cnt;
    logic              tx_pop_req, tx_pop, tx_push_ok;
    logic [DATA_W-1:0] tx_head;

    assign tx_head    = tx_mem[tx_rp];
    assign tx_pop     = tx_pop_req & (tx_cnt != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign tx_push_ok = data_wr & ((tx_cnt != FULL_CNT) | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp] <= databus[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)     tx_rp <= tx_rp + 1'b1;
            case ({tx_push_ok, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    bit_state_t        tx_state, tx_next;
    logic [4:0]        tx_tcnt;
    logic [2:0]        tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_par;
    logic [4:0]        tx_last_tick;
    logic              tx_bit_end;

    always_comb begin
        tx_last_tick = (tx_state == S_STOP) ? 5'(STOP_TICKS - 1) : 5'd15;
        tx_bit_end   = tick & (tx_tcnt == tx_last_tick);
    end

    always_comb begin
        tx_next    = tx_state;
        tx_pop_req = 1'b0;
        txd        = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (tick && (tx_cnt != '0)) begin
                    tx_next    = S_START;
                    tx_pop_req = 1'b1;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                txd = tx_shift[0];
                if (tx_bit_end && (tx_bit == LAST_BIT))
                    tx_next = PAR_ON ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                txd = tx_par;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next frame when one is queued.
                if (tx_bit_end) begin
                    if (tx_cnt != '0) begin
                        tx_next    = S_START;
                        tx_pop_req = 1'b1;
                    end else begin
                        tx_next = S_IDLE;
                    end
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ ODD;
                tx_tcnt  <= '0;
                tx_bit   <= '0;
            end else if (tick && (tx_state != S_IDLE)) begin
                if (tx_bit_end) begin
                    tx_tcnt <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_tcnt <= tx_tcnt + 5'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser
    // ------------------------------------------------------------------
    logic rx_m, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wp, rx_rp;
    logic [CW-1:0]     rx_cnt;
    logic              rx_pop, rx_push_ok, rx_frame_ok;
    logic [DATA_W-1:0] rx_shift;

    assign rx_pop     = data_rd & (rx_cnt != '0);
    assign rx_push_ok = rx_frame_ok & ((rx_cnt != FULL_CNT) | rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)     rx_rp <= rx_rp + 1'b1;
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    // The tick that detects the start edge counts as tick 0; rx_tcnt == 7
    // on a tick is tick 8 of the bit (its centre) and 15 is the last tick.
    bit_state_t rx_state, rx_next;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic       rx_par_bad;
    logic       rx_mid, rx_end;
    logic       set_fe, set_pe, set_ov;

    assign rx_mid = tick & (rx_tcnt == 4'd7);
    assign rx_end = tick & (rx_tcnt == 4'd15);

    always_comb begin
        rx_next     = rx_state;
        rx_frame_ok = 1'b0;
        set_fe      = 1'b0;
        set_pe      = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (tick && !rx_s) rx_next = S_START;
            end
            S_START: begin
                if (rx_mid && rx_s) rx_next = S_IDLE;   // false start
                else if (rx_end)    rx_next = S_DATA;
            end
            S_DATA: begin
                if (rx_end && (rx_bit == LAST_BIT))
                    rx_next = PAR_ON ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (rx_end) rx_next = S_STOP;
            end
            S_STOP: begin
                // Finish at mid-stop so the next start edge is never missed.
                if (rx_mid) begin
                    rx_next = S_IDLE;
                    if (!rx_s)          set_fe      = 1'b1;
                    else if (rx_par_bad) set_pe     = 1'b1;
                    else                rx_frame_ok = 1'b1;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    assign set_ov = rx_frame_ok & ~rx_push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= S_IDLE;
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == S_IDLE) begin
                rx_tcnt    <= '0;
                rx_bit     <= '0;
                rx_par_bad <= 1'b0;
            end else if (tick) begin
                rx_tcnt <= rx_tcnt + 4'd1;
                if (rx_mid && (rx_state == S_DATA))
                    rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
                if (rx_mid && (rx_state == S_PARITY))
                    rx_par_bad <= (rx_s != ((^rx_shift) ^ ODD));
                if (rx_end && (rx_state == S_DATA))
                    rx_bit <= rx_bit + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status: {overrun, parity_err, frame_err}
    // ------------------------------------------------------------------
    logic [2:0] sticky;
    logic [2:0] sticky_clr;

    assign sticky_clr = stat_wr ? databus[4:2] : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) sticky <= '0;
        else     sticky <= (sticky & ~sticky_clr) | {set_ov, set_pe, set_fe};
    end

    // ------------------------------------------------------------------
    // Flags and read mux
    // ------------------------------------------------------------------
    logic [7:0] rx_head_ext;
    logic [7:0] bus_out;

    assign rda = (rx_cnt != '0);
    assign tbr = (tx_cnt != FULL_CNT);

    always_comb begin
        rx_head_ext = 8'h00;
        if (rx_cnt != '0) rx_head_ext[DATA_W-1:0] = rx_mem[rx_rp];
    end

    always_comb begin
        bus_out = 8'h00;
        if (data_rd)      bus_out = rx_head_ext;
        else if (stat_rd) bus_out = {3'b000, sticky, rda, tbr};
    end

    assign databus = (data_rd | stat_rd) ? bus_out : 8'hzz;

endmodule

// File: tb/tb_spart_fifo.sv
// -----------------------------------------------------------------------------
// tb_spart_fifo -- directed bench for spart_fifo.
// dut   : default parameters (8N1, depth 4, DIV_RST 325); divisor set to 3,
//         so one serial bit is 64 clocks. rxd is either looped from txd or
//         driven by the bench.
// dut_p : even parity enabled, DIV_RST 3, rxd driven by the bench.
// -----------------------------------------------------------------------------
module tb_spart_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut bus / serial
    logic       iocs = 1'b0, iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] dbus_drv = 8'h00;
    logic       dbus_en = 1'b0;
    wire  [7:0] databus;
    logic       rda, tbr, txd;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;
    logic       rxd;

    // dut_p bus / serial
    logic       pcs = 1'b0, prw = 1'b0;
    logic [1:0] paddr = 2'b00;
    logic [7:0] pbus_drv = 8'h00;
    logic       pbus_en = 1'b0;
    wire  [7:0] pbus;
    logic       prda, ptbr, ptxd;
    logic       rxp_drv = 1'b1;

    assign databus = dbus_en ? dbus_drv : 8'hzz;
    assign pbus    = pbus_en ? pbus_drv : 8'hzz;
    assign rxd     = loop ? txd : rx_drv;

    spart_fifo dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    spart_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .DIV_RST(16'd3)) dut_p (
        .clk(clk), .rst(rst), .iocs(pcs), .iorw(prw), .ioaddr(paddr),
        .databus(pbus), .rda(prda), .tbr(ptbr), .txd(ptxd), .rxd(rxp_drv)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // sel = 0 addresses dut, sel = 1 addresses dut_p
    task automatic bus_write(input bit sel, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin pcs = 1; prw = 0; paddr = a; pbus_drv = d; pbus_en = 1; end
        else     begin iocs = 1; iorw = 0; ioaddr = a; dbus_drv = d; dbus_en = 1; end
        @(negedge clk);
        pcs = 0; pbus_en = 0; iocs = 0; dbus_en = 0;
    endtask

    task automatic bus_read(input bit sel, input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        if (sel) begin pcs = 1; prw = 1; paddr = a; end
        else     begin iocs = 1; iorw = 1; ioaddr = a; end
        #1;
        d = sel ? pbus : databus;
        @(negedge clk);
        pcs = 0; iocs = 0;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rxp_drv = v;
        else     rx_drv  = v;
    endtask

    // Drive one 64-clock-per-bit frame, then one idle bit time.
    task automatic send_rx(input bit sel, input logic [7:0] data, input bit with_par,
                           input logic par, input logic stopv);
        set_rx(sel, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, data[i]);
            repeat (64) @(negedge clk);
        end
        if (with_par) begin
            set_rx(sel, par);
            repeat (64) @(negedge clk);
        end
        set_rx(sel, stopv);
        repeat (64) @(negedge clk);
        set_rx(sel, 1'b1);
        repeat (64) @(negedge clk);
    endtask

    // Returns at the first negedge where txd is low (bounded).
    task automatic wait_txd_low(input int budget, input string tag);
        int n;
        n = 0;
        while ((txd !== 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, txd === 1'b0}, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] val;
        int         n;
        logic       stayed_high;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rda", {31'd0, rda}, 32'd0);
        check("rst_tbr", {31'd0, tbr}, 32'd1);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_ptxd", {31'd0, ptxd}, 32'd1);
        check("rst_ptbr", {31'd0, ptbr}, 32'd1);
        bus_read(0, 2'b01, d);
        check("rst_status", {24'd0, d}, 32'h01);
        bus_read(0, 2'b00, d);
        check("rd_empty", {24'd0, d}, 32'h00);
        bus_read(1, 2'b01, d);
        check("p_rst_status", {24'd0, d}, 32'h01);

        bus_write(0, 2'b10, 8'd3);
        bus_write(0, 2'b11, 8'd0);

        // ---------------- TX waveform of 8'hA5 ----------------
        val = 8'hA5;
        bus_write(0, 2'b00, val);
        wait_txd_low(64, "a5_start_seen");
        repeat (63) @(negedge clk);
        check("a5_start_len", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (32) @(negedge clk);
            check($sformatf("a5_bit%0d", i), {31'd0, txd}, {31'd0, val[i]});
            check("a5_tbr", {31'd0, tbr}, 32'd1);
            repeat (32) @(negedge clk);
        end
        repeat (32) @(negedge clk);
        check("a5_stop", {31'd0, txd}, 32'd1);
        repeat (100) @(negedge clk);
        check("a5_idle", {31'd0, txd}, 32'd1);

        // ---------------- loopback 3C, C3 ----------------
        loop = 1'b1;
        bus_write(0, 2'b00, 8'h3C);
        bus_write(0, 2'b00, 8'hC3);
        n = 0;
        while (!rda && n < 1500) begin @(negedge clk); n++; end
        check("lb_rda_frame1", {31'd0, rda}, 32'd1);
        repeat (800) @(negedge clk);
        bus_read(0, 2'b00, d);
        check("lb_data1", {24'd0, d}, 32'h3C);
        bus_read(0, 2'b00, d);
        check("lb_data2", {24'd0, d}, 32'hC3);
        bus_read(0, 2'b00, d);
        check("lb_data3_empty", {24'd0, d}, 32'h00);
        check("lb_rda_low", {31'd0, rda}, 32'd0);

        // ---------------- TX FIFO full, fifth write dropped ----------------
        // A priming frame keeps TX busy while four more writes fill the FIFO.
        bus_write(0, 2'b00, 8'h11);
        exp_q.push_back(8'h11);
        wait_txd_low(64, "full_busy");
        bus_write(0, 2'b00, 8'h21); exp_q.push_back(8'h21);
        bus_write(0, 2'b00, 8'h22); exp_q.push_back(8'h22);
        bus_write(0, 2'b00, 8'h23); exp_q.push_back(8'h23);
        check("full_tbr_3", {31'd0, tbr}, 32'd1);
        bus_write(0, 2'b00, 8'h24); exp_q.push_back(8'h24);
        check("full_tbr_4", {31'd0, tbr}, 32'd0);
        bus_write(0, 2'b00, 8'h25);
        check("full_tbr_5", {31'd0, tbr}, 32'd0);
        n = 0;
        while (n < 4500) begin
            if (rda) begin
                bus_read(0, 2'b00, d);
                if (exp_q.size() > 0) check("full_rx_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
                else                  check("full_rx_extra", {24'd0, d}, 32'h1FF);
                n += 2;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check("full_rx_missing", exp_q.size(), 32'd0);
        bus_read(0, 2'b01, d);
        check("full_status", {24'd0, d}, 32'h01);

        // ---------------- framing error ----------------
        loop = 1'b0;
        repeat (20) @(negedge clk);
        send_rx(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        bus_read(0, 2'b01, d);
        check("fe_status", {24'd0, d & 8'hFE}, 32'h04);
        check("fe_tbr_bit", {31'd0, d[0]}, 32'd1);
        check("fe_rda", {31'd0, rda}, 32'd0);
        bus_write(0, 2'b01, 8'h04);
        bus_read(0, 2'b01, d);
        check("fe_cleared", {24'd0, d & 8'hFE}, 32'h00);
        send_rx(0, 8'h96, 1'b0, 1'b0, 1'b1);
        bus_read(0, 2'b00, d);
        check("rx_good_96", {24'd0, d}, 32'h96);

        // ---------------- parity (even) ----------------
        send_rx(1, 8'h01, 1'b1, 1'b0, 1'b1);
        bus_read(1, 2'b01, d);
        check("pe_status", {24'd0, d}, 32'h09);
        check("pe_rda", {31'd0, prda}, 32'd0);
        send_rx(1, 8'h01, 1'b1, 1'b1, 1'b1);
        bus_read(1, 2'b01, d);
        check("pe_good_status", {24'd0, d}, 32'h0B);
        bus_read(1, 2'b00, d);
        check("pe_good_data", {24'd0, d}, 32'h01);
        bus_write(1, 2'b01, 8'h08);
        set_rx(1, 1'b0);
        repeat (16) @(negedge clk);
        set_rx(1, 1'b1);
        repeat (800) @(negedge clk);
        bus_read(1, 2'b01, d);
        check("glitch_status", {24'd0, d}, 32'h01);

        // ---------------- reset mid-frame ----------------
        bus_write(0, 2'b00, 8'hF0);
        bus_write(0, 2'b00, 8'h0F);
        wait_txd_low(64, "mid_start");
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_txd", {31'd0, txd}, 32'd1);
        check("mid_tbr", {31'd0, tbr}, 32'd1);
        check("mid_rda", {31'd0, rda}, 32'd0);
        stayed_high = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        check("mid_no_residual", {31'd0, stayed_high}, 32'd1);
        bus_read(0, 2'b01, d);
        check("mid_status", {24'd0, d}, 32'h01);
        // Divisor back at 325: a start bit lasts 16 * 326 clocks.
        bus_write(0, 2'b00, 8'h01);
        wait_txd_low(700, "div_start");
        repeat (16 * 326 - 1) @(negedge clk);
        check("div_start_len", {31'd0, txd}, 32'd0);
        @(negedge clk);
        check("div_bit0", {31'd0, txd}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
